pipe_bubble_skid: RTL and testbench
===================================

// Module: pipe_bubble_skid
// PURPOSE
//  Consumer-side pipeline stage register for the pipelined MIPS datapath.
//  Accepts 65-bit pipe words from the hazard/stall-inserting stage via valid/ready and
//  buffers them in a 2-entry skid buffer so downstream backpressure never drops a word.
//  Decodes the bubble encoding {1'b1, 64'd0} and flags it to the EX side.
// PARAMETERS
//  SIZE   65  pipe word width; bit SIZE-1 = bubble tag, bits SIZE-2:0 = payload
//  CNT_W  16  bubble counter width (used only with PIPE_BUBBLE_CNT_EN)
// PORTS
//  clk_i        in   1      clock, all state on rising edge
//  rst_i        in   1      asynchronous, active-low reset
//  in_valid_i   in   1      upstream word valid
//  in_ready_o   out  1      block can accept a word this cycle
//  data_i       in   SIZE   upstream pipe word
//  out_valid_o  out  1      data_o holds a valid word
//  out_ready_i  in   1      downstream accepts data_o this cycle
//  data_o       out  SIZE   head pipe word
//  bubble_o     out  1      out_valid_o && data_o == BUBBLE
//  flush_i      in   1      synchronous squash of all buffered words
//  bubble_cnt_o out  CNT_W  bubbles accepted (present only with PIPE_BUBBLE_CNT_EN)
// BEHAVIOUR
//  Reset (rst_i=0, async): state EMPTY, main/skid=0, data_o=0, out_valid_o=0,
//   bubble_o=0, in_ready_o=1, bubble_cnt_o=0.
//  Accept = in_valid_i & in_ready_o; Send = out_valid_o & out_ready_i.
//  in_ready_o = (state!=FULL); out_valid_o = (state!=EMPTY); data_o = main. All are
//   decodes of registered state; no combinational path from in_valid_i/out_ready_i.
//  FSM states EMPTY/ONE/FULL:
//   EMPTY: Accept -> ONE, main<=data_i.
//   ONE:   Accept&Send -> ONE, main<=data_i; Accept only -> FULL, skid<=data_i;
//          Send only -> EMPTY; neither -> hold.
//   FULL:  Send -> ONE, main<=skid; else hold (no Accept possible).
//  Latency: word accepted at edge N appears on data_o after edge N (1 cycle); full
//   throughput when out_ready_i held high. Words leave in acceptance order.
//  BUBBLE = {1'b1,{SIZE-1{1'b0}}}; bit SIZE-1 set with nonzero payload is an ordinary
//   word (bubble_o=0). Bubbles occupy slots and are forwarded like any word.
//  flush_i=1: highest priority; next state EMPTY, main/skid<=0; a word offered the same
//   cycle is dropped; Send in that cycle still counts downstream. Counter unaffected.
//  Async reset mid-transfer: everything to reset values immediately; buffered words lost.
//  Upstream must hold data_i stable while in_valid_i=1 & in_ready_o=0 (not checked).
// CONFIGURATION
//  PIPE_BUBBLE_CNT_EN defined: bubble_cnt_o increments on every Accept of BUBBLE,
//   saturates at 2^CNT_W-1, not cleared by flush_i.
//  Undefined: bubble_cnt_o port and counter absent; all other behaviour identical.
// STRUCTURE
//  pipe_pkg: PIPE_W=65, BUBBLE word constant, state typedef {EMPTY,ONE,FULL} 2-bit.
//  No sub-module; FSM, two data registers, and counter live in one module.
// TESTING
//  Reset then Accept 0x0_0000_0000_2002_0005 with out_ready_i=1 -> data_o matches next
//   cycle, out_valid_o=1, bubble_o=0.
//  out_ready_i=0, offer A,B,C back-to-back -> A,B accepted, in_ready_o=0 on 3rd cycle;
//   out_ready_i=1 -> A,B,C emitted in order, none lost/duplicated.
//  Offer {1'b1,64'd0} -> bubble_o=1 at output; offer {1'b1,64'd1} -> bubble_o=0.
//  FULL then flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1,
//   offered word discarded.
//  Assert rst_i=0 asynchronously between clocks while FULL -> outputs to reset values
//   before next edge.
//  PIPE_BUBBLE_CNT_EN, CNT_W=2: accept 5 bubbles -> bubble_cnt_o=3; flush -> stays 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipe-word definitions for the MIPS pipeline stage registers: word width,
// the bubble encoding and the skid-buffer occupancy states.
package pipe_pkg;

  localparam int PIPE_W = 65;

  // A bubble is the tag bit alone; tag with any payload bit set is a real word.
  localparam logic [PIPE_W-1:0] PIPE_BUBBLE = {1'b1, {(PIPE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skidState_t;

  function automatic logic isBubble(input logic [PIPE_W-1:0] word);
    return word == PIPE_BUBBLE;
  endfunction

endpackage

// File: rtl/pipe_bubble_skid.sv
// Consumer-side pipe stage register with a 2-entry skid buffer and bubble decode.
// Optional bubble counter (bubble_cnt_o) is built only when PIPE_BUBBLE_CNT_EN is defined.
module pipe_bubble_skid
  import pipe_pkg::*;
#(
  parameter int SIZE  = PIPE_W,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SIZE-1:0]  data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SIZE-1:0]  data_o,
  output logic             bubble_o,
  input  logic             flush_i
`ifdef PIPE_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt_o
`endif
);

  localparam logic [SIZE-1:0] BUBBLE_WORD = {1'b1, {(SIZE-1){1'b0}}};

  skidState_t      r_state;
  skidState_t      w_stateNext;
  logic [SIZE-1:0] r_main;
  logic [SIZE-1:0] r_skid;
  logic            w_accept;
  logic            w_send;
  logic            w_loadMainIn;
  logic            w_loadMainSkid;
  logic            w_loadSkid;

  // Handshake outputs decode registered state only, so ready never depends on valid.
  assign in_ready_o  = (r_state != FULL);
  assign out_valid_o = (r_state != EMPTY);
  assign data_o      = r_main;
  assign bubble_o    = out_valid_o && (r_main == BUBBLE_WORD);

  assign w_accept = in_valid_i & in_ready_o;
  assign w_send   = out_valid_o & out_ready_i;

  always_comb begin
    w_stateNext    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    if (flush_i) begin
      w_stateNext = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_stateNext  = ONE;
            w_loadMainIn = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_send) begin
            w_loadMainIn = 1'b1;
          end else if (w_accept) begin
            w_stateNext = FULL;
            w_loadSkid  = 1'b1;
          end else if (w_send) begin
            w_stateNext = EMPTY;
          end
        end
        FULL: begin
          if (w_send) begin
            w_stateNext    = ONE;
            w_loadMainSkid = 1'b1;
          end
        end
        default: w_stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_stateNext;
      if (flush_i) begin
        r_main <= '0;
        r_skid <= '0;
      end else begin
        if (w_loadMainIn) begin
          r_main <= data_i;
        end else if (w_loadMainSkid) begin
          r_main <= r_skid;
        end
        if (w_loadSkid) begin
          r_skid <= data_i;
        end
      end
    end
  end

`ifdef PIPE_BUBBLE_CNT_EN
  logic [CNT_W-1:0] r_bubbleCnt;
  logic             w_countBubble;

  // A word offered during a flush is dropped, so it is not counted as accepted.
  assign w_countBubble = w_accept && !flush_i && (data_i == BUBBLE_WORD)
                         && (r_bubbleCnt != {CNT_W{1'b1}});

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bubbleCnt <= '0;
    end else if (w_countBubble) begin
      r_bubbleCnt <= r_bubbleCnt + CNT_W'(1);
    end
  end

  assign bubble_cnt_o = r_bubbleCnt;
`endif

endmodule

// File: tb/tb_pipe_bubble_skid.sv
// Directed self-checking bench for pipe_bubble_skid; counter checks run when
// PIPE_BUBBLE_CNT_EN is defined (DUT then built with CNT_W=2).
module tb_pipe_bubble_skid;

  localparam int W = 65;
  localparam int CW = 2;

  logic          clk;
  logic          rstN;
  logic          inValid;
  logic          inReady;
  logic [W-1:0]  dataIn;
  logic          outValid;
  logic          outReady;
  logic [W-1:0]  dataOut;
  logic          bubble;
  logic          flush;
`ifdef PIPE_BUBBLE_CNT_EN
  logic [CW-1:0] bubbleCnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [W-1:0] WORD0  = 65'h0_0000_0000_2002_0005;
  localparam logic [W-1:0] WORDA  = 65'h0_1111_2222_3333_4444;
  localparam logic [W-1:0] WORDB  = 65'h0_5555_6666_7777_8888;
  localparam logic [W-1:0] WORDC  = 65'h1_9999_AAAA_BBBB_CCCC;
  localparam logic [W-1:0] BUBW   = {1'b1, 64'd0};
  localparam logic [W-1:0] NOTBUB = {1'b1, 64'd1};

  pipe_bubble_skid #(
    .SIZE  (W),
    .CNT_W (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rstN),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .data_i      (dataIn),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .data_o      (dataOut),
    .bubble_o    (bubble),
    .flush_i     (flush)
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    .bubble_cnt_o(bubbleCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then let the edge happen and sample 1ns after it.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                               input logic rdy, input logic fl);
    inValid  = v;
    dataIn   = d;
    outReady = rdy;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_outValid"}, W'(outValid), W'(0));
    checkOutput({tag, "_inReady"},  W'(inReady),  W'(1));
    checkOutput({tag, "_data"},     dataOut,      W'(0));
    checkOutput({tag, "_bubble"},   W'(bubble),   W'(0));
  endtask

  initial begin
    rstN = 1'b0; inValid = 1'b0; dataIn = '0; outReady = 1'b0; flush = 1'b0;
    #3;
    checkIdleOutputs("reset");
`ifdef PIPE_BUBBLE_CNT_EN
    checkOutput("reset_cnt", W'(bubbleCnt), W'(0));
`endif
    #9 rstN = 1'b1;

    // Single word passes through with one cycle latency.
    applyStimulus(1'b1, WORD0, 1'b1, 1'b0);
    checkOutput("pass_data",     dataOut,       WORD0);
    checkOutput("pass_outValid", W'(outValid),  W'(1));
    checkOutput("pass_bubble",   W'(bubble),    W'(0));
    checkOutput("pass_inReady",  W'(inReady),   W'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("pass_drain", W'(outValid), W'(0));

    // Backpressure: A,B fill the buffer, C must wait.
    applyStimulus(1'b1, WORDA, 1'b0, 1'b0);
    checkOutput("bp_a_inReady", W'(inReady), W'(1));
    checkOutput("bp_a_data",    dataOut,     WORDA);
    applyStimulus(1'b1, WORDB, 1'b0, 1'b0);
    checkOutput("bp_b_inReady", W'(inReady), W'(0));
    checkOutput("bp_b_data",    dataOut,     WORDA);
    applyStimulus(1'b1, WORDC, 1'b0, 1'b0);
    checkOutput("bp_c_inReady", W'(inReady), W'(0));
    checkOutput("bp_c_data",    dataOut,     WORDA);
    applyStimulus(1'b1, WORDC, 1'b1, 1'b0);
    checkOutput("bp_out1_data",    dataOut,     WORDB);
    checkOutput("bp_out1_inReady", W'(inReady), W'(1));
    applyStimulus(1'b1, WORDC, 1'b1, 1'b0);
    checkOutput("bp_out2_data",     dataOut,      WORDC);
    checkOutput("bp_out2_outValid", W'(outValid), W'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("bp_drain", W'(outValid), W'(0));

    // Bubble decode: only the exact bubble encoding raises bubble_o.
    applyStimulus(1'b1, BUBW, 1'b1, 1'b0);
    checkOutput("bub_flag", W'(bubble), W'(1));
    checkOutput("bub_data", dataOut,    BUBW);
    applyStimulus(1'b1, NOTBUB, 1'b1, 1'b0);
    checkOutput("notbub_flag",  W'(bubble),   W'(0));
    checkOutput("notbub_valid", W'(outValid), W'(1));
    checkOutput("notbub_data",  dataOut,      NOTBUB);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Flush while full drops buffered words and the word offered alongside.
    applyStimulus(1'b1, WORDA, 1'b0, 1'b0);
    applyStimulus(1'b1, WORDB, 1'b0, 1'b0);
    checkOutput("fl_full", W'(inReady), W'(0));
    applyStimulus(1'b1, WORDC, 1'b0, 1'b1);
    checkIdleOutputs("flush");
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("fl_dropped", W'(outValid), W'(0));

    // Async reset between edges while full.
    applyStimulus(1'b1, WORDA, 1'b0, 1'b0);
    applyStimulus(1'b1, WORDB, 1'b0, 1'b0);
    inValid = 1'b0;
    checkOutput("ar_prefull", W'(inReady), W'(0));
    #2 rstN = 1'b0;
    #1;
    checkIdleOutputs("asyncReset");
    #3 rstN = 1'b1;

`ifdef PIPE_BUBBLE_CNT_EN
    // Counter saturates at 3 with a 2-bit width and survives a flush.
    applyStimulus(1'b1, BUBW, 1'b1, 1'b0);
    applyStimulus(1'b1, BUBW, 1'b1, 1'b0);
    checkOutput("cnt_two", W'(bubbleCnt), W'(2));
    applyStimulus(1'b1, BUBW, 1'b1, 1'b0);
    applyStimulus(1'b1, BUBW, 1'b1, 1'b0);
    applyStimulus(1'b1, BUBW, 1'b1, 1'b0);
    checkOutput("cnt_sat", W'(bubbleCnt), W'(3));
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("cnt_flush", W'(bubbleCnt), W'(3));
`endif

    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
